pe_tree_mac: RTL

- Parametrised successor to the fixed 8-input PE tree. LANES sign-magnitude Qm.Q multiply pairs feed a pipelined binary adder tree.
- A run-time group-size select replaces the per-PE enable lines, so one instance yields the full sum, pairwise sums, quad sums, etc.
- Adds a per-group accumulator across beats, saturation with overflow flag, and valid/ready flow control.
- Sits between the CNN window/weight feeders and the activation stage.

---
 rtl/pe_tree_mac.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pe_tree_mac.sv
// Sign-magnitude multiply lanes feeding a pipelined adder tree with a run-time group size,
// per-group accumulation, output saturation and valid/ready flow control.
module pe_tree_mac #(
    parameter int unsigned N         = 32,
    parameter int unsigned Q         = 15,
    parameter int unsigned LANES     = 8,
    parameter int unsigned ACC_GUARD = 8,
    localparam int unsigned L        = $clog2(LANES),
    localparam int unsigned GW       = $clog2(L + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*N-1:0] in_data,
    input  logic [LANES*N-1:0] in_w,
    input  logic [GW-1:0]      in_grp,
    input  logic               in_first,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] out_data,
    output logic               out_ovf
);

    localparam int unsigned TW   = N + 1 + L;
    localparam int unsigned AW   = TW + ACC_GUARD;
    localparam int unsigned PW   = 2 * N - 2;
    localparam logic [N-2:0] MAXM = {(N-1){1'b1}};
    localparam logic [GW-1:0] LG  = GW'(L);

    // Tree levels 0..L: level 0 holds products, level j holds group sums of size 2^min(j,grp)
    logic [L:0]               r_vld, r_first, r_last, r_ovf;
    logic [GW-1:0]            r_grp [L+1];
    logic signed [TW-1:0]     r_tree [L+1][LANES];
    logic signed [AW-1:0]     r_acc [LANES];
    logic                     r_acc_ovf;
    logic                     r_out_valid;
    logic [LANES*N-1:0]       r_out_data;
    logic                     r_out_ovf;

    logic                     w_en;
    logic signed [N:0]        w_prod [LANES];
    logic [LANES-1:0]         w_psat;
    logic signed [AW-1:0]     w_acc_nx [LANES];
    logic [LANES-1:0]         w_lane_sat;
    logic [LANES*N-1:0]       w_out_nx;
    logic                     w_ovf_nx;

    assign w_en      = !(r_out_valid && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

    for (genvar k = 0; k < LANES; k++) begin : g_mul
        logic [N-1:0]  w_a, w_b;
        logic [PW-1:0] w_full, w_shr;
        logic [N-2:0]  w_mag;
        assign w_a       = in_data[k*N +: N];
        assign w_b       = in_w[k*N +: N];
        assign w_full    = PW'(w_a[N-2:0]) * PW'(w_b[N-2:0]);
        assign w_shr     = w_full >> Q;
        assign w_psat[k] = w_shr > PW'(MAXM);
        assign w_mag     = w_psat[k] ? MAXM : w_shr[N-2:0];
        assign w_prod[k] = (w_a[N-1] ^ w_b[N-1]) ? -$signed({2'b00, w_mag})
                                                  : $signed({2'b00, w_mag});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_ovf   <= '0;
            for (int j = 0; j <= L; j++) begin
                r_grp[j] <= '0;
                for (int i = 0; i < LANES; i++) r_tree[j][i] <= '0;
            end
        end else if (w_en) begin
            r_vld[0]   <= in_valid;
            r_first[0] <= in_first;
            r_last[0]  <= in_last;
            r_ovf[0]   <= |w_psat;
            r_grp[0]   <= (in_grp > LG) ? LG : in_grp;
            for (int i = 0; i < LANES; i++) r_tree[0][i] <= TW'(w_prod[i]);
            for (int j = 1; j <= L; j++) begin
                r_vld[j]   <= r_vld[j-1];
                r_first[j] <= r_first[j-1];
                r_last[j]  <= r_last[j-1];
                r_ovf[j]   <= r_ovf[j-1];
                r_grp[j]   <= r_grp[j-1];
                for (int i = 0; i < LANES; i++) r_tree[j][i] <= r_tree[j-1][i];
                // Merge only up to the group level; above it, group sums pass through
                if (r_grp[j-1] >= GW'(j)) begin
                    for (int i = 0; i < LANES / 2; i++) begin
                        r_tree[j][i] <= (i < (LANES >> j))
                                        ? r_tree[j-1][2*i] + r_tree[j-1][2*i+1] : '0;
                    end
                    for (int i = LANES / 2; i < LANES; i++) r_tree[j][i] <= '0;
                end
            end
        end
    end

    assign w_ovf_nx = r_first[L] ? r_ovf[L] : (r_acc_ovf | r_ovf[L]);

    for (genvar i = 0; i < LANES; i++) begin : g_out
        logic signed [AW-1:0] w_sum;
        logic [AW-1:0]        w_abs;
        logic                 w_neg, w_sat, w_live;
        logic [N-2:0]         w_mag;
        assign w_sum         = AW'(r_tree[L][i]);
        assign w_acc_nx[i]   = r_first[L] ? w_sum : r_acc[i] + w_sum;
        assign w_neg         = w_acc_nx[i][AW-1];
        assign w_abs         = w_neg ? -w_acc_nx[i] : w_acc_nx[i];
        assign w_sat         = w_abs > AW'(MAXM);
        assign w_mag         = w_sat ? MAXM : w_abs[N-2:0];
        assign w_live        = i < (LANES >> r_grp[L]);
        assign w_lane_sat[i] = w_sat & w_live;
        // A negative acc always has a nonzero magnitude, so -0 cannot be produced
        assign w_out_nx[i*N +: N] = w_live ? {w_neg, w_mag} : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
            r_acc_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_vld[L] & r_last[L];
            if (r_vld[L]) begin
                for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_nx[i];
                r_acc_ovf <= w_ovf_nx;
                if (r_last[L]) begin
                    r_out_data <= w_out_nx;
                    r_out_ovf  <= w_ovf_nx | (|w_lane_sat);
                end
            end
        end
    end

endmodule
